conv_mac_ctrl: RTL

CONV_MAC_CTRL -- requirements
Module: conv_mac_ctrl

---
 rtl/conv_mac_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/conv_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_ctrl
// Brief    : Sequencer for linear convolution z = x * y through an external MAC.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  size_x,
    input  logic [4:0]  size_y,
    output logic [4:0]  memx_addr,
    input  logic [7:0]  memx_data,
    output logic [4:0]  memy_addr,
    input  logic [7:0]  memy_data,
    output logic [7:0]  mac_x,
    output logic [7:0]  mac_y,
    output logic        mac_clr_n,
    output logic        mac_load,
    input  logic [15:0] mac_z,
    output logic [5:0]  memz_addr,
    output logic [15:0] memz_data,
    output logic        memz_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ADDR  = 3'd2,
        S_MAC   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [4:0]  r_sx;
    logic [4:0]  r_sy;
    logic [5:0]  r_i;
    logic [5:0]  r_k;
    logic [5:0]  r_kend;
    logic [5:0]  r_last;
    logic [4:0]  r_xaddr;
    logic [4:0]  r_yaddr;
    logic [5:0]  r_zaddr;
    logic        r_clr_n;
    logic        r_load;
    logic        r_we;
    logic        r_busy;
    logic        r_done;

    logic [5:0]  w_i_plus1;
    logic [5:0]  w_sx_m1;
    logic [5:0]  w_k_start;
    logic [5:0]  w_kend;

    // First and last valid k for output i: k >= i-(size_y-1), k <= min(i, size_x-1)
    always_comb begin
        w_i_plus1 = r_i + 6'd1;
        w_sx_m1   = {1'b0, r_sx} - 6'd1;
        w_k_start = 6'd0;
        if (w_i_plus1 > {1'b0, r_sy}) begin
            w_k_start = w_i_plus1 - {1'b0, r_sy};
        end
        w_kend = (r_i < w_sx_m1) ? r_i : w_sx_m1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sx    <= 5'd0;
            r_sy    <= 5'd0;
            r_i     <= 6'd0;
            r_k     <= 6'd0;
            r_kend  <= 6'd0;
            r_last  <= 6'd0;
            r_xaddr <= 5'd0;
            r_yaddr <= 5'd0;
            r_zaddr <= 6'd0;
            r_clr_n <= 1'b0;
            r_load  <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_clr_n <= 1'b1;
                    r_load  <= 1'b0;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    if (start) begin
                        if ((size_x != 5'd0) && (size_y != 5'd0)) begin
                            r_sx    <= size_x;
                            r_sy    <= size_y;
                            r_last  <= {1'b0, size_x} + {1'b0, size_y} - 6'd2;
                            r_i     <= 6'd0;
                            r_clr_n <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_CLEAR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_CLEAR: begin
                    r_clr_n <= 1'b1;
                    r_k     <= w_k_start;
                    r_kend  <= w_kend;
                    r_xaddr <= w_k_start[4:0];
                    r_yaddr <= r_i[4:0] - w_k_start[4:0];
                    r_state <= S_ADDR;
                end

                // Memory data for the current address lands during MAC
                S_ADDR: begin
                    r_load  <= 1'b1;
                    r_state <= S_MAC;
                end

                S_MAC: begin
                    r_load <= 1'b0;
                    if (r_k == r_kend) begin
                        r_we    <= 1'b1;
                        r_zaddr <= r_i;
                        r_state <= S_WRITE;
                    end else begin
                        r_k     <= r_k + 6'd1;
                        r_xaddr <= r_k[4:0] + 5'd1;
                        r_yaddr <= r_yaddr - 5'd1;
                        r_state <= S_ADDR;
                    end
                end

                S_WRITE: begin
                    r_we <= 1'b0;
                    if (r_i == r_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i     <= w_i_plus1;
                        r_clr_n <= 1'b0;
                        r_state <= S_CLEAR;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_clr_n <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_clr_n <= 1'b1;
                    r_load  <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The accumulator result is only meaningful in WRITE, after the last MAC edge
    assign memz_data = r_we ? mac_z : 16'd0;
    assign mac_clr_n = r_clr_n & ~rst;
    assign mac_x     = memx_data;
    assign mac_y     = memy_data;
    assign memx_addr = r_xaddr;
    assign memy_addr = r_yaddr;
    assign memz_addr = r_zaddr;
    assign memz_we   = r_we;
    assign mac_load  = r_load;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
